// File: rtl/keynsham_spi.sv
// keynsham_spi: memory-mapped SPI master (mode 0, MSB first, 8-bit frames).
// Bus slave on the OR-combined Keynsham data bus; one byte per TXDATA write,
// software-controlled active-low slave selects, single-cycle registered ack.
module keynsham_spi #(
  parameter int nr_cs = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_access,
  input  logic             bus_cs,
  input  logic [29:0]      bus_addr,
  input  logic [31:0]      bus_wr_val,
  input  logic             bus_wr_en,
  input  logic [3:0]       bus_bytesel,
  output logic [31:0]      bus_data,
  output logic             bus_ack,
  output logic             bus_error,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic [nr_cs-1:0] spi_cs_n
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [7:0]       div_r, div_nxt_s;
  logic [3:0]       cs_en_r, cs_en_nxt_s;
  logic [nr_cs-1:0] cs_n_r;
  logic [7:0]       phase_r, phase_nxt_s;
  logic [2:0]       bit_cnt_r, bit_nxt_s;
  logic [7:0]       tx_shift_r, tx_nxt_s;
  logic [7:0]       rx_shift_r, rx_nxt_s;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r, rx_valid_nxt_s;
  logic             sclk_r, sclk_nxt_s;
  logic             mosi_r, mosi_nxt_s;
  logic [31:0]      bus_data_r;
  logic             bus_ack_r, bus_error_r;

  logic        acc_s, wr_s, rd_s, busy_s;
  logic        err_s, ctrl_wr_s, start_s, rx_rd_s;
  logic [31:0] rd_data_s;
  logic        phase_done_s, done_s;
  logic        unused_bits_s;

  // Only the low word-address bits and the low 12 data bits are meaningful.
  assign unused_bits_s = ^{bus_addr[29:2], bus_wr_val[31:12]};

  // Bus decode: register select, error qualification and read mux.
  always_comb begin
    acc_s     = bus_access & bus_cs;
    wr_s      = acc_s & bus_wr_en;
    rd_s      = acc_s & ~bus_wr_en;
    busy_s    = (state_r != ST_IDLE);
    err_s     = 1'b0;
    ctrl_wr_s = 1'b0;
    start_s   = 1'b0;
    rx_rd_s   = 1'b0;
    rd_data_s = 32'd0;
    case (bus_addr[1:0])
      2'd0: begin
        rd_data_s = {20'd0, cs_en_r, div_r};
        err_s     = wr_s & busy_s;
        ctrl_wr_s = wr_s & ~busy_s;
      end
      2'd1: begin
        rd_data_s = {30'd0, rx_valid_r, busy_s};
        err_s     = wr_s;
      end
      2'd2: begin
        rd_data_s = 32'd0;
        err_s     = rd_s | (wr_s & busy_s);
        start_s   = wr_s & ~busy_s & bus_bytesel[0];
      end
      2'd3: begin
        rd_data_s = {24'd0, rx_data_r};
        err_s     = wr_s;
        rx_rd_s   = rd_s;
      end
      default: begin
        rd_data_s = 32'd0;
        err_s     = 1'b0;
      end
    endcase
  end

  // Transfer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: each half period lasts div+1 cycles, eight bits per frame.
  always_comb begin
    phase_done_s = (phase_r == div_r);
    state_nxt_s  = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = start_s ? ST_LOW : ST_IDLE;
      ST_LOW:  state_nxt_s = phase_done_s ? ST_HIGH : ST_LOW;
      ST_HIGH: begin
        if (phase_done_s) begin
          state_nxt_s = (bit_cnt_r == 3'd7) ? ST_IDLE : ST_LOW;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; sclk and mosi are registered off the next state.
  always_comb begin
    tx_nxt_s  = tx_shift_r;
    rx_nxt_s  = rx_shift_r;
    bit_nxt_s = bit_cnt_r;
    done_s    = 1'b0;
    if ((state_r == ST_IDLE) || (state_nxt_s != state_r)) begin
      phase_nxt_s = 8'd0;
    end else begin
      phase_nxt_s = phase_r + 8'd1;
    end
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          tx_nxt_s  = bus_wr_val[7:0];
          bit_nxt_s = 3'd0;
        end else begin
          tx_nxt_s  = tx_shift_r;
        end
      end
      ST_LOW: begin
        if (phase_done_s) begin
          rx_nxt_s = {rx_shift_r[6:0], spi_miso};
        end else begin
          rx_nxt_s = rx_shift_r;
        end
      end
      ST_HIGH: begin
        if (phase_done_s) begin
          tx_nxt_s  = {tx_shift_r[6:0], 1'b0};
          bit_nxt_s = bit_cnt_r + 3'd1;
          done_s    = (bit_cnt_r == 3'd7);
        end else begin
          tx_nxt_s  = tx_shift_r;
        end
      end
      default: begin
        tx_nxt_s = tx_shift_r;
      end
    endcase
    sclk_nxt_s = (state_nxt_s == ST_HIGH);
    mosi_nxt_s = (state_nxt_s == ST_LOW) ? tx_nxt_s[7] : mosi_r;
    // Completion wins over a coincident RXDATA read.
    if (done_s) begin
      rx_valid_nxt_s = 1'b1;
    end else if (rx_rd_s) begin
      rx_valid_nxt_s = 1'b0;
    end else begin
      rx_valid_nxt_s = rx_valid_r;
    end
    div_nxt_s   = (ctrl_wr_s && bus_bytesel[0]) ? bus_wr_val[7:0]  : div_r;
    cs_en_nxt_s = (ctrl_wr_s && bus_bytesel[1]) ? bus_wr_val[11:8] : cs_en_r;
  end

  // Datapath, control and SPI pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r      <= 8'd0;
      cs_en_r    <= 4'd0;
      cs_n_r     <= {nr_cs{1'b1}};
      phase_r    <= 8'd0;
      bit_cnt_r  <= 3'd0;
      tx_shift_r <= 8'd0;
      rx_shift_r <= 8'd0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      div_r      <= div_nxt_s;
      cs_en_r    <= cs_en_nxt_s;
      cs_n_r     <= ~cs_en_nxt_s[nr_cs-1:0];
      phase_r    <= phase_nxt_s;
      bit_cnt_r  <= bit_nxt_s;
      tx_shift_r <= tx_nxt_s;
      rx_shift_r <= rx_nxt_s;
      rx_data_r  <= done_s ? rx_shift_r : rx_data_r;
      rx_valid_r <= rx_valid_nxt_s;
      sclk_r     <= sclk_nxt_s;
      mosi_r     <= mosi_nxt_s;
    end
  end

  // Bus response: one-cycle ack, data zero unless acking a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack_r   <= 1'b0;
      bus_error_r <= 1'b0;
      bus_data_r  <= 32'd0;
    end else begin
      bus_ack_r   <= acc_s;
      bus_error_r <= err_s;
      bus_data_r  <= rd_s ? rd_data_s : 32'd0;
    end
  end

  assign bus_data  = bus_data_r;
  assign bus_ack   = bus_ack_r;
  assign bus_error = bus_error_r;
  assign spi_sclk  = sclk_r;
  assign spi_mosi  = mosi_r;
  assign spi_cs_n  = cs_n_r;

endmodule

// File: tb/tb_keynsham_spi.sv
// Directed self-checking bench for keynsham_spi.
module tb_keynsham_spi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_access = 1'b0;
  logic        bus_cs = 1'b0;
  logic [29:0] bus_addr = 30'd0;
  logic [31:0] bus_wr_val = 32'd0;
  logic        bus_wr_en = 1'b0;
  logic [3:0]  bus_bytesel = 4'd0;
  logic [31:0] bus_data;
  logic        bus_ack, bus_error;
  logic        spi_sclk, spi_mosi, spi_miso;
  logic [3:0]  spi_cs_n;
  logic        miso_loop = 1'b0;
  logic        miso_val = 1'b0;

  int checks = 0;
  int failures = 0;

  assign spi_miso = miso_loop ? spi_mosi : miso_val;

  keynsham_spi #(.nr_cs(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_access(bus_access), .bus_cs(bus_cs),
    .bus_addr(bus_addr), .bus_wr_val(bus_wr_val), .bus_wr_en(bus_wr_en),
    .bus_bytesel(bus_bytesel), .bus_data(bus_data), .bus_ack(bus_ack),
    .bus_error(bus_error), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic [3:0] bs);
    bus_access = 1'b1; bus_cs = 1'b1; bus_wr_en = wr;
    bus_addr = {28'd0, a}; bus_wr_val = d; bus_bytesel = bs;
  endtask

  task automatic idle_bus();
    bus_access = 1'b0; bus_cs = 1'b0; bus_wr_en = 1'b0;
  endtask

  task automatic bus_xfer(input logic wr, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] bs, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    drive(wr, a, d, bs);
    @(negedge clk);
    check("ack", 32'(bus_ack), 32'd1);
    rdata = bus_data;
    err = bus_error;
    idle_bus();
  endtask

  task automatic wr_chk(input string tag, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] bs, input logic exp_err);
    logic [31:0] r;
    logic e;
    bus_xfer(1'b1, a, d, bs, r, e);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] r;
    logic e;
    bus_xfer(1'b0, a, 32'd0, 4'd0, r, e);
    check({tag, "_data"}, r, exp);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  // Start a transfer, then poll STATUS every cycle while watching the SPI pins.
  task automatic run_xfer(input string tag, input logic [7:0] txb, input int div,
                          input logic [7:0] exp_mosi);
    int busy_n = 0;
    int rises = 0;
    int highs = 0;
    int first_rise = 0;
    logic prev = 1'b0;
    logic [7:0] mbits = 8'd0;
    logic done = 1'b0;
    logic [31:0] last = 32'hFFFF_FFFF;
    @(negedge clk);
    drive(1'b1, 2'd2, {24'd0, txb}, 4'b0001);
    @(negedge clk);
    check({tag, "_tx_ack"}, 32'(bus_ack), 32'd1);
    check({tag, "_tx_err"}, 32'(bus_error), 32'd0);
    drive(1'b0, 2'd1, 32'd0, 4'd0);
    for (int i = 1; i <= 2000 && !done; i++) begin
      @(negedge clk);
      if (spi_sclk && !prev) begin
        rises++;
        mbits = {mbits[6:0], spi_mosi};
        if (first_rise == 0) first_rise = i;
      end
      if (spi_sclk) highs++;
      prev = spi_sclk;
      if (bus_data[0]) busy_n++;
      else begin
        done = 1'b1;
        last = bus_data;
      end
    end
    idle_bus();
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(16 * (div + 1)));
    check({tag, "_sclk_rises"}, 32'(rises), 32'd8);
    check({tag, "_sclk_high_cycles"}, 32'(highs), 32'(8 * (div + 1)));
    check({tag, "_first_rise"}, 32'(first_rise), 32'(div + 1));
    check({tag, "_mosi_bits"}, 32'(mbits), 32'(exp_mosi));
    check({tag, "_status_end"}, last, 32'd2);
  endtask

  logic [31:0] tmp_r;
  logic        tmp_e;
  logic        seen;

  initial begin
    // Reset state
    #12;
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'hF);
    check("rst_ack", 32'(bus_ack), 32'd0);
    check("rst_error", 32'(bus_error), 32'd0);
    check("rst_data", bus_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rst_status", 2'd1, 32'd0, 1'b0);
    rd_chk("rst_ctrl", 2'd0, 32'd0, 1'b0);
    rd_chk("rst_rxdata", 2'd3, 32'd0, 1'b0);

    // div=2, cs_en=3, loopback 0xA5
    wr_chk("ctrl_302", 2'd0, 32'h0000_0302, 4'hF, 1'b0);
    rd_chk("ctrl_302_rb", 2'd0, 32'h0000_0302, 1'b0);
    check("cs_n_1100", 32'(spi_cs_n), 32'hC);
    miso_loop = 1'b1;
    run_xfer("a5", 8'hA5, 2, 8'hA5);
    check("cs_n_after_a5", 32'(spi_cs_n), 32'hC);
    rd_chk("rx_a5", 2'd3, 32'h0000_00A5, 1'b0);

    // div=0, miso tied high, send 0x00
    wr_chk("ctrl_300", 2'd0, 32'h0000_0300, 4'hF, 1'b0);
    miso_loop = 1'b0;
    miso_val = 1'b1;
    run_xfer("div0", 8'h00, 0, 8'h00);
    rd_chk("rx_ff", 2'd3, 32'h0000_00FF, 1'b0);
    rd_chk("status_cleared", 2'd1, 32'd0, 1'b0);
    rd_chk("rx_ff_again", 2'd3, 32'h0000_00FF, 1'b0);

    // Errors while busy; the rejected byte must not be queued
    wr_chk("ctrl_302b", 2'd0, 32'h0000_0302, 4'hF, 1'b0);
    miso_loop = 1'b1;
    wr_chk("tx_3c", 2'd2, 32'h0000_003C, 4'b0001, 1'b0);
    wr_chk("tx_busy", 2'd2, 32'h0000_00FF, 4'b0001, 1'b1);
    wr_chk("ctrl_busy", 2'd0, 32'h0000_0001, 4'hF, 1'b1);
    rd_chk("ctrl_unchanged", 2'd0, 32'h0000_0302, 1'b0);
    rd_chk("status_busy", 2'd1, 32'd1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      bus_xfer(1'b0, 2'd1, 32'd0, 4'd0, tmp_r, tmp_e);
      if (!tmp_r[0]) seen = 1'b1;
    end
    check("busy_drop", 32'(seen), 32'd1);
    check("busy_drop_status", tmp_r, 32'd2);
    rd_chk("rx_3c", 2'd3, 32'h0000_003C, 1'b0);
    rd_chk("not_queued", 2'd1, 32'd0, 1'b0);
    wr_chk("wr_rxdata", 2'd3, 32'h0000_0011, 4'hF, 1'b1);
    wr_chk("wr_status", 2'd1, 32'h0000_0003, 4'hF, 1'b1);
    rd_chk("rd_txdata", 2'd2, 32'd0, 1'b1);
    @(negedge clk);
    check("ack_low", 32'(bus_ack), 32'd0);
    check("data_zero_no_ack", bus_data, 32'd0);

    // RXDATA read landing on the completion edge
    wr_chk("ctrl_300b", 2'd0, 32'h0000_0300, 4'hF, 1'b0);
    miso_loop = 1'b0;
    miso_val = 1'b0;
    @(negedge clk);
    drive(1'b1, 2'd2, 32'h0000_005A, 4'b0001);
    @(negedge clk);
    idle_bus();
    repeat (15) @(negedge clk);
    drive(1'b0, 2'd3, 32'd0, 4'd0);
    @(negedge clk);
    check("race_ack", 32'(bus_ack), 32'd1);
    check("race_old_byte", bus_data, 32'h0000_003C);
    idle_bus();
    rd_chk("race_status", 2'd1, 32'd2, 1'b0);
    rd_chk("race_new_byte", 2'd3, 32'd0, 1'b0);

    // Byte-lane CTRL write
    wr_chk("ctrl_107", 2'd0, 32'h0000_0107, 4'hF, 1'b0);
    wr_chk("ctrl_lane1", 2'd0, 32'h0000_0F55, 4'b0010, 1'b0);
    rd_chk("ctrl_lane1_rb", 2'd0, 32'h0000_0F07, 1'b0);
    check("cs_n_0000", 32'(spi_cs_n), 32'h0);

    // Asynchronous reset mid-transfer
    wr_chk("ctrl_f02", 2'd0, 32'h0000_0F02, 4'hF, 1'b0);
    miso_loop = 1'b1;
    wr_chk("tx_ff", 2'd2, 32'h0000_00FF, 4'b0001, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (spi_sclk) seen = 1'b1;
    end
    check("sclk_high_before_reset", 32'(seen), 32'd1);
    drive(1'b0, 2'd1, 32'd0, 4'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sclk", 32'(spi_sclk), 32'd0);
    check("mid_rst_mosi", 32'(spi_mosi), 32'd0);
    check("mid_rst_cs_n", 32'(spi_cs_n), 32'hF);
    check("mid_rst_ack", 32'(bus_ack), 32'd0);
    check("mid_rst_data", bus_data, 32'd0);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_status", 2'd1, 32'd0, 1'b0);
    rd_chk("post_rst_ctrl", 2'd0, 32'd0, 1'b0);
    rd_chk("post_rst_rx", 2'd3, 32'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("post_rst_sclk_idle", 32'(spi_sclk), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
